// File: rtl/mmio_uart_pkg.sv
// MMIO register offsets and TX drain FSM states shared by the UART hub.
package mmio_uart_pkg;

  localparam logic [3:0] RX_DATA_OFS  = 4'hF;
  localparam logic [3:0] RX_COUNT_OFS = 4'hE;
  localparam logic [3:0] TX_DATA_OFS  = 4'hC;
  localparam logic [3:0] TX_FREE_OFS  = 4'h8;
  localparam logic [3:0] STATUS_OFS   = 4'h0;

  typedef enum logic [1:0] {TX_IDLE, TX_PULSE, TX_WAIT} tx_state_t;

endpackage

// File: rtl/mmio_uart_hub_ring_fifo.sv
// Ring buffer, combinational head, one push and one pop per cycle; when full a push
// either overwrites the oldest entry (OVERWRITE=1) or is dropped, flagged by ovf_pulse.
module ring_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             overwrite;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign pop_ok    = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full buffer is not an overflow then.
  assign ovf_pulse = push & full & ~pop_ok;
  assign overwrite = ovf_pulse & OVERWRITE;
  assign push_ok   = push & (~ovf_pulse | overwrite);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok | overwrite) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok & ~overwrite & ~pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (pop_ok & ~push_ok) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_uart_hub.sv
// MMIO/DDR2 hub with UART RX ring and TX FIFO; MMIO reads are same-cycle and never stall,
// DDR2 stall passes through. MMIO_UART_STATUS_EN builds the STATUS register and sticky flags.
module mmio_uart_hub
  import mmio_uart_pkg::*;
#(
  parameter int RX_DEPTH = 512,
  parameter int TX_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_ready,
  input  logic [31:0] data,
  input  logic        m_data_en,
  input  logic        m_data_we,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wd,
  output logic [31:0] m_data_rd,
  output logic        m_data_stall,
  output logic        tx_start,
  output logic [7:0]  sdata,
  input  logic        tx_busy,
  output logic        ddr2_en,
  output logic        ddr2_we,
  output logic [31:0] ddr2_addr,
  output logic [31:0] ddr2_wd,
  input  logic [31:0] ddr2_rd,
  input  logic        ddr2_stall
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic             mmio;
  logic [3:0]       ofs;
  logic [31:0]      mmio_rd;
  logic             rx_pop;
  logic [31:0]      rx_head;
  logic [RX_CW-1:0] rx_count;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_ovf_pulse;
  logic             tx_push;
  logic             tx_pop;
  logic [7:0]       tx_head;
  logic [TX_CW-1:0] tx_count;
  logic [TX_CW-1:0] tx_free;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_drop_pulse;

  tx_state_t        state;
  tx_state_t        state_n;
  logic             tx_start_n;
  logic [7:0]       sdata_n;
  logic             wait_seen;
  logic             wait_seen_n;

  assign mmio    = m_data_en & m_data_addr[31];
  assign ofs     = m_data_addr[3:0];
  assign rx_pop  = mmio & ~m_data_we & (ofs == RX_DATA_OFS);
  assign tx_push = mmio &  m_data_we & (ofs == TX_DATA_OFS);
  assign tx_free = TX_CW'(TX_DEPTH) - tx_count;

  assign ddr2_en      = m_data_en & ~m_data_addr[31];
  assign ddr2_we      = m_data_we;
  assign ddr2_addr    = m_data_addr;
  assign ddr2_wd      = m_data_wd;
  assign m_data_stall = ~m_data_addr[31] & ddr2_stall;
  assign m_data_rd    = mmio ? mmio_rd : ddr2_rd;

  ring_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH), .OVERWRITE(1'b1)) u_rx (
    .clock     (clock),
    .reset     (reset),
    .push      (data_ready),
    .push_data (data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .ovf_pulse (rx_ovf_pulse)
  );

  ring_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH), .OVERWRITE(1'b0)) u_tx (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (m_data_wd[7:0]),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty),
    .ovf_pulse (tx_drop_pulse)
  );

`ifdef MMIO_UART_STATUS_EN
  logic rx_ovf;
  logic tx_drop;
  logic status_rd;

  assign status_rd = mmio & ~m_data_we & (ofs == STATUS_OFS);

  // A new event in the same cycle as the clearing read keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ovf  <= 1'b0;
      tx_drop <= 1'b0;
    end else begin
      if (rx_ovf_pulse)   rx_ovf <= 1'b1;
      else if (status_rd) rx_ovf <= 1'b0;
      if (tx_drop_pulse)  tx_drop <= 1'b1;
      else if (status_rd) tx_drop <= 1'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{rx_ovf_pulse, tx_drop_pulse, tx_full};
`endif

  logic unused_rx_full;
  assign unused_rx_full = rx_full;

  always_comb begin
    mmio_rd = '0;
    case (ofs)
      RX_DATA_OFS:  mmio_rd = rx_empty ? 32'd0 : rx_head;
      RX_COUNT_OFS: mmio_rd = 32'(rx_count);
      TX_FREE_OFS:  mmio_rd = 32'(tx_free);
`ifdef MMIO_UART_STATUS_EN
      STATUS_OFS:   mmio_rd = {28'd0, tx_full, rx_empty, tx_drop, rx_ovf};
`endif
      default:      mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= TX_IDLE;
      tx_start  <= 1'b0;
      sdata     <= '0;
      wait_seen <= 1'b0;
    end else begin
      state     <= state_n;
      tx_start  <= tx_start_n;
      sdata     <= sdata_n;
      wait_seen <= wait_seen_n;
    end
  end

  // UartTx raises busy a cycle late, so the first WAIT cycle never returns to IDLE.
  always_comb begin
    state_n     = state;
    tx_start_n  = 1'b0;
    sdata_n     = sdata;
    wait_seen_n = wait_seen;
    tx_pop      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (~tx_empty & ~tx_busy) begin
          tx_pop     = 1'b1;
          sdata_n    = tx_head;
          tx_start_n = 1'b1;
          state_n    = TX_PULSE;
        end
      end
      TX_PULSE: begin
        wait_seen_n = 1'b0;
        state_n     = TX_WAIT;
      end
      TX_WAIT: begin
        wait_seen_n = 1'b1;
        if (wait_seen & ~tx_busy) state_n = TX_IDLE;
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Directed checks of the UART hub with RX_DEPTH=4 and TX_DEPTH=4.
module tb_mmio_uart_hub;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        data_ready = 1'b0;
  logic [31:0] data = '0;
  logic        m_data_en = 1'b0;
  logic        m_data_we = 1'b0;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wd = '0;
  logic [31:0] m_data_rd;
  logic        m_data_stall;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy = 1'b0;
  logic        ddr2_en;
  logic        ddr2_we;
  logic [31:0] ddr2_addr;
  logic [31:0] ddr2_wd;
  logic [31:0] ddr2_rd = '0;
  logic        ddr2_stall = 1'b0;

  int vec = 0;
  int errs = 0;
  logic [7:0] tx_q[$];

  mmio_uart_hub #(.RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .data_ready(data_ready), .data(data),
    .m_data_en(m_data_en), .m_data_we(m_data_we), .m_data_addr(m_data_addr),
    .m_data_wd(m_data_wd), .m_data_rd(m_data_rd), .m_data_stall(m_data_stall),
    .tx_start(tx_start), .sdata(sdata), .tx_busy(tx_busy),
    .ddr2_en(ddr2_en), .ddr2_we(ddr2_we), .ddr2_addr(ddr2_addr),
    .ddr2_wd(ddr2_wd), .ddr2_rd(ddr2_rd), .ddr2_stall(ddr2_stall)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_start) tx_q.push_back(sdata);
  end

  task automatic mmio_read(input logic [3:0] ofs, output logic [31:0] v);
    @(negedge clock);
    m_data_en = 1'b1; m_data_we = 1'b0; m_data_addr = {28'h8000000, ofs};
    #2 v = m_data_rd;
    @(posedge clock); #1;
    m_data_en = 1'b0;
  endtask

  task automatic mmio_write(input logic [3:0] ofs, input logic [31:0] wd);
    @(negedge clock);
    m_data_en = 1'b1; m_data_we = 1'b1; m_data_addr = {28'h8000000, ofs}; m_data_wd = wd;
    @(posedge clock); #1;
    m_data_en = 1'b0; m_data_we = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] v);
    @(negedge clock);
    data_ready = 1'b1; data = v;
    @(posedge clock); #1;
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
    vec++; if (sdata !== 8'h00) begin errs++; $display("FAIL reset_sdata got=%h want=00", sdata); end
    reset = 1'b0;
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL reset_rx_count got=%0d want=0", v); end
    mmio_read(4'h8, v);
    vec++; if (v !== 32'd4) begin errs++; $display("FAIL reset_tx_free got=%0d want=4", v); end
  endtask

  task automatic test_rx_basic;
    logic [31:0] v;
    rx_push(32'h11); rx_push(32'h22);
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd2) begin errs++; $display("FAIL rx_count2 got=%0d want=2", v); end
    mmio_read(4'hF, v);
    vec++; if (v !== 32'h11) begin errs++; $display("FAIL rx_pop1 got=%h want=11", v); end
    mmio_read(4'hF, v);
    vec++; if (v !== 32'h22) begin errs++; $display("FAIL rx_pop2 got=%h want=22", v); end
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL rx_count0 got=%0d want=0", v); end
    mmio_read(4'hF, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL rx_pop_empty got=%h want=0", v); end
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL rx_count_after_empty_pop got=%0d want=0", v); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] v;
    logic [31:0] exp_words [4] = '{32'd2, 32'd3, 32'd4, 32'd5};
    for (int i = 1; i <= 5; i++) rx_push(32'(i));
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd4) begin errs++; $display("FAIL ovf_count got=%0d want=4", v); end
    mmio_read(4'h0, v);
`ifdef MMIO_UART_STATUS_EN
    vec++; if (v !== 32'h1) begin errs++; $display("FAIL ovf_status1 got=%h want=1", v); end
    mmio_read(4'h0, v);
    vec++; if (v !== 32'h0) begin errs++; $display("FAIL ovf_status_clear got=%h want=0", v); end
`else
    vec++; if (v !== 32'h0) begin errs++; $display("FAIL status_disabled got=%h want=0", v); end
`endif
    for (int i = 0; i < 4; i++) begin
      mmio_read(4'hF, v);
      vec++; if (v !== exp_words[i]) begin errs++; $display("FAIL ovf_pop%0d got=%h want=%h", i, v, exp_words[i]); end
    end
  endtask

  task automatic test_rx_full_push_pop;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) rx_push(32'h100 + 32'(i));
    @(negedge clock);
    data_ready = 1'b1; data = 32'h104;
    m_data_en = 1'b1; m_data_we = 1'b0; m_data_addr = 32'h8000_000F;
    #2 v = m_data_rd;
    @(posedge clock); #1;
    data_ready = 1'b0; m_data_en = 1'b0;
    vec++; if (v !== 32'h100) begin errs++; $display("FAIL pushpop_head got=%h want=100", v); end
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd4) begin errs++; $display("FAIL pushpop_count got=%0d want=4", v); end
`ifdef MMIO_UART_STATUS_EN
    mmio_read(4'h0, v);
    vec++; if (v !== 32'h0) begin errs++; $display("FAIL pushpop_no_ovf got=%h want=0", v); end
`endif
    for (int i = 1; i <= 4; i++) begin
      mmio_read(4'hF, v);
      vec++; if (v !== 32'h100 + 32'(i)) begin errs++; $display("FAIL pushpop_drain%0d got=%h want=%h", i, v, 32'h100 + 32'(i)); end
    end
  endtask

  task automatic test_tx;
    logic [31:0] v;
    logic [7:0] exp_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int guard;
    tx_busy = 1'b1;
    tx_q.delete();
    for (int i = 0; i < 5; i++) mmio_write(4'hC, 32'hFFFF_FFA1 + 32'(i) - 32'hFFFF_FF00);
    mmio_read(4'h8, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL tx_free_full got=%0d want=0", v); end
`ifdef MMIO_UART_STATUS_EN
    mmio_read(4'h0, v);
    vec++; if (v !== 32'hE) begin errs++; $display("FAIL tx_status got=%h want=e", v); end
    mmio_read(4'h0, v);
    vec++; if (v !== 32'hC) begin errs++; $display("FAIL tx_status_clear got=%h want=c", v); end
`endif
    repeat (4) @(posedge clock);
    vec++; if (tx_q.size() !== 0) begin errs++; $display("FAIL tx_no_start_busy got=%0d want=0", tx_q.size()); end
    @(negedge clock); tx_busy = 1'b0;
    guard = 0;
    while (tx_q.size() < 4 && guard < 60) begin @(negedge clock); guard++; end
    repeat (10) @(negedge clock);
    vec++; if (tx_q.size() !== 4) begin errs++; $display("FAIL tx_pulse_count got=%0d want=4", tx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (i >= tx_q.size()) begin errs++; $display("FAIL tx_byte%0d got=none want=%h", i, exp_b[i]); end
      else if (tx_q[i] !== exp_b[i]) begin errs++; $display("FAIL tx_byte%0d got=%h want=%h", i, tx_q[i], exp_b[i]); end
    end
    mmio_read(4'h8, v);
    vec++; if (v !== 32'd4) begin errs++; $display("FAIL tx_free_drained got=%0d want=4", v); end
  endtask

  task automatic test_ddr2;
    logic [31:0] v;
    ddr2_stall = 1'b1; ddr2_rd = 32'hDEAD_BEEF;
    @(negedge clock);
    m_data_en = 1'b1; m_data_we = 1'b0; m_data_addr = 32'h0000_1234;
    #2;
    vec++; if (m_data_stall !== 1'b1) begin errs++; $display("FAIL ddr_stall got=%b want=1", m_data_stall); end
    vec++; if (ddr2_en !== 1'b1) begin errs++; $display("FAIL ddr_en got=%b want=1", ddr2_en); end
    vec++; if (ddr2_addr !== 32'h1234) begin errs++; $display("FAIL ddr_addr got=%h want=1234", ddr2_addr); end
    vec++; if (m_data_rd !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ddr_rd got=%h want=deadbeef", m_data_rd); end
    @(negedge clock);
    m_data_we = 1'b1; m_data_wd = 32'hCAFE_0001; m_data_addr = 32'h0000_0040;
    #2;
    vec++; if ({ddr2_we, ddr2_wd} !== {1'b1, 32'hCAFE_0001}) begin errs++; $display("FAIL ddr_write got=%b/%h want=1/cafe0001", ddr2_we, ddr2_wd); end
    @(posedge clock); #1;
    m_data_en = 1'b0; m_data_we = 1'b0;
    rx_push(32'h5); rx_push(32'h6);
    @(negedge clock);
    m_data_en = 1'b1; m_data_we = 1'b0; m_data_addr = 32'h8000_000E;
    #2;
    vec++; if (m_data_stall !== 1'b0) begin errs++; $display("FAIL mmio_stall got=%b want=0", m_data_stall); end
    vec++; if (ddr2_en !== 1'b0) begin errs++; $display("FAIL mmio_ddr_en got=%b want=0", ddr2_en); end
    vec++; if (m_data_rd !== 32'd2) begin errs++; $display("FAIL mmio_count_rd got=%h want=2", m_data_rd); end
    @(posedge clock); #1;
    m_data_en = 1'b0;
    mmio_read(4'h4, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL unmapped_rd got=%h want=0", v); end
    ddr2_stall = 1'b0;
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] v;
    int guard;
    tx_busy = 1'b0;
    mmio_write(4'hC, 32'hB7);
    mmio_write(4'hC, 32'hB8);
    guard = 0;
    @(negedge clock);
    while (!tx_start && guard < 20) begin @(negedge clock); guard++; end
    vec++; if (tx_start !== 1'b1) begin errs++; $display("FAIL mid_tx_pulse got=%b want=1", tx_start); end
    vec++; if (sdata !== 8'hB7) begin errs++; $display("FAIL mid_tx_byte got=%h want=b7", sdata); end
    reset = 1'b1;
    @(posedge clock); #1;
    vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL mid_reset_tx_start got=%b want=0", tx_start); end
    vec++; if (sdata !== 8'h00) begin errs++; $display("FAIL mid_reset_sdata got=%h want=00", sdata); end
    @(negedge clock); reset = 1'b0;
    tx_q.delete();
    mmio_read(4'h8, v);
    vec++; if (v !== 32'd4) begin errs++; $display("FAIL mid_reset_tx_free got=%0d want=4", v); end
    mmio_read(4'hE, v);
    vec++; if (v !== 32'd0) begin errs++; $display("FAIL mid_reset_rx_count got=%0d want=0", v); end
    repeat (10) @(negedge clock);
    vec++; if (tx_q.size() !== 0) begin errs++; $display("FAIL mid_reset_pending_sent got=%0d want=0", tx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_overflow();
    test_rx_full_push_pop();
    test_tx();
    test_ddr2();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
